// File: rtl/load_store_unit_if.sv
// Data-memory handshake between the load/store unit (master) and the memory (slave).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one handshaked data-memory access per core request, with lane
// steering, load extension, legality/alignment checks and a bus timeout.
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  load_store_unit_if.master mem
);
  // state | meaning
  // IDLE  | wait for req_valid; decode, then launch or reject
  // BUSY  | mem_req held with registered bus fields until mem_ready or timeout
  // DONE  | one-cycle done pulse, err/rdata valid
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [31:0]   addr_q, wd_q;
  logic [3:0]    be_q;
  logic          err_d;
  logic [31:0]   rdata_d;
  logic          launch, legal, aligned;
  logic [3:0]    be_req;
  logic [31:0]   wd_req, ld_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    be_req  = '0;
    wd_req  = '0;
    case (funct3)
      3'b000, 3'b100: begin
        legal   = !req_we || (funct3 == 3'b000);
        aligned = 1'b1;
        be_req  = 4'b0001 << addr[1:0];
        wd_req  = {4{wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        legal   = !req_we || (funct3 == 3'b001);
        aligned = !addr[0];
        be_req  = 4'b0011 << addr[1:0];
        wd_req  = {2{wdata[15:0]}};
      end
      3'b010: begin
        legal   = 1'b1;
        aligned = (addr[1:0] == 2'b00);
        be_req  = 4'b1111;
        wd_req  = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem.mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = mem.mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err     <= err_d;
      rdata   <= rdata_d;
      if (launch) begin
        we_q   <= req_we;
        f3_q   <= funct3;
        off_q  <= addr[1:0];
        addr_q <= {addr[31:2], 2'b00};
        wd_q   <= wd_req;
        be_q   <= be_req;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err;
    rdata_d = rdata;
    launch  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        // reset gating keeps stall low while the unit is held in reset
        stall = req_valid && reset;
        if (req_valid) begin
          if (legal && aligned) begin
            launch  = 1'b1;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (mem.mem_ready) begin
          rdata_d = we_q ? 32'd0 : ld_data;
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done          = (state_q == DONE);
  assign mem.mem_req   = (state_q == BUSY);
  assign mem.mem_we    = mem.mem_req && we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = mem.mem_req ? be_q : 4'd0;
  assign mem.mem_wdata = mem.mem_req ? wd_q : 32'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences for timeout
// and mid-access reset, and randomized requests against a behavioural model.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        stall, done, err;
  logic [31:0] rdata;

  load_store_unit_if mif ();

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .err(err), .rdata(rdata), .mem(mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat; int busy;
    logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic we;
    logic unstable; logic stall_idle; logic stall_busy_bad; logic stall_done;
    logic err; logic [31:0] rdata; logic req_done; logic [3:0] be_done;
    logic [31:0] wd_done; logic done_next; logic hung; logic gap;
  } obs_t;

  typedef struct {
    logic err; logic [31:0] rdata; logic [3:0] be; logic [31:0] wd; int busy; int lat;
  } exp_t;

  typedef struct {
    logic we; logic [2:0] f3; logic [31:0] a; logic [31:0] wd; int dly; logic [31:0] mrd; exp_t e;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endfunction

  // Expected outcome from the ISA rules: size from funct3, alignment by modulo,
  // lane data by multiplication, extension by arithmetic on the extracted value.
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int dly, input logic [31:0] mrd);
    exp_t e;
    int o, size;
    longint v;
    e = '{default: 0};
    o = int'(a % 4);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0 || (we && f3 >= 3'd4) || (o % size) != 0) begin
      e.err = 1'b1;
      e.lat = 2;
      return e;
    end
    e.be = 4'(((1 << size) - 1) << o);
    e.wd = (size == 1) ? wd[7:0] * 32'h01010101 : (size == 2) ? wd[15:0] * 32'h00010001 : wd;
    if (dly >= TO) begin
      e.busy = TO;
      e.err  = 1'b1;
    end else begin
      e.busy = dly + 1;
      if (!we) begin
        v = (longint'(mrd) >> (8 * o)) % (longint'(1) << (8 * size));
        if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
          v = v - (longint'(1) << (8 * size));
        e.rdata = v[31:0];
      end
    end
    e.lat = e.busy + 2;
    return e;
  endfunction

  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int dly, input logic [31:0] mrd,
                        output obs_t o);
    bit fin;
    o = '{default: 0};
    fin = 1'b0;
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    mif.mem_ready = 1'b0;
    #1 o.stall_idle = stall;
    o.lat = 1;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(posedge clk); #1;
      o.lat++;
      if (done) begin
        fin = 1'b1;
        o.err = err; o.rdata = rdata; o.stall_done = stall;
        o.req_done = mif.mem_req; o.be_done = mif.mem_be; o.wd_done = mif.mem_wdata;
        req_valid = 1'b0;
        mif.mem_ready = 1'b0;
      end else if (mif.mem_req) begin
        o.busy++;
        if (o.busy == 1) begin
          o.addr = mif.mem_addr; o.be = mif.mem_be; o.wd = mif.mem_wdata; o.we = mif.mem_we;
        end else if (o.addr !== mif.mem_addr || o.be !== mif.mem_be ||
                     o.wd !== mif.mem_wdata || o.we !== mif.mem_we) begin
          o.unstable = 1'b1;
        end
        if (!stall) o.stall_busy_bad = 1'b1;
        if (o.busy == dly + 1) begin
          mif.mem_ready = 1'b1; mif.mem_rdata = mrd;
        end else begin
          mif.mem_ready = 1'b0; mif.mem_rdata = $urandom;
        end
      end else begin
        o.gap = 1'b1;
      end
    end
    if (!fin) begin
      o.hung = 1'b1;
      req_valid = 1'b0;
      mif.mem_ready = 1'b0;
    end
    @(posedge clk); #1;
    o.done_next = done;
  endtask

  task automatic check_txn(input string nm, input obs_t o, input exp_t e,
                           input logic we, input logic [31:0] a);
    chk($sformatf("%s no_done_timeout", nm), 32'(o.hung), 32'd0);
    chk($sformatf("%s latency", nm), o.lat, e.lat);
    chk($sformatf("%s busy_cycles", nm), o.busy, e.busy);
    chk($sformatf("%s err", nm), 32'(o.err), 32'(e.err));
    chk($sformatf("%s rdata", nm), o.rdata, e.rdata);
    chk($sformatf("%s stall_idle", nm), 32'(o.stall_idle), 32'd1);
    chk($sformatf("%s stall_busy_low", nm), 32'(o.stall_busy_bad), 32'd0);
    chk($sformatf("%s stall_done", nm), 32'(o.stall_done), 32'd0);
    chk($sformatf("%s idle_gap", nm), 32'(o.gap), 32'd0);
    chk($sformatf("%s req_in_done", nm), 32'(o.req_done), 32'd0);
    chk($sformatf("%s be_in_done", nm), 32'(o.be_done), 32'd0);
    chk($sformatf("%s wdata_in_done", nm), o.wd_done, 32'd0);
    chk($sformatf("%s done_one_cycle", nm), 32'(o.done_next), 32'd0);
    if (e.busy > 0) begin
      chk($sformatf("%s mem_addr", nm), o.addr, a & 32'hFFFF_FFFC);
      chk($sformatf("%s mem_be", nm), 32'(o.be), 32'(e.be));
      chk($sformatf("%s mem_we", nm), 32'(o.we), 32'(we));
      chk($sformatf("%s bus_stable", nm), 32'(o.unstable), 32'd0);
      if (we) chk($sformatf("%s mem_wdata", nm), o.wd, e.wd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[15];
    obs_t  o;
    exp_t  e;
    logic  r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_wd, r_mrd;
    int    r_dly;

    tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,       0, 32'hDEADBEEF, '{1'b0, 32'hDEADBEEF, 4'hF, 32'h0,       1, 3}};
    tbl[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,       0, 32'h80FF1234, '{1'b0, 32'hFFFFFF80, 4'h8, 32'h0,       1, 3}};
    tbl[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,       0, 32'h80FF1234, '{1'b0, 32'h00000080, 4'h8, 32'h0,       1, 3}};
    tbl[3]  = '{1'b0, 3'b101, 32'h102, 32'h0,       0, 32'h80FF1234, '{1'b0, 32'h000080FF, 4'hC, 32'h0,       1, 3}};
    tbl[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,       0, 32'h80FF1234, '{1'b0, 32'hFFFF80FF, 4'hC, 32'h0,       1, 3}};
    tbl[5]  = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'h0,       '{1'b0, 32'h0,       4'hC, 32'hABCDABCD, 4, 6}};
    tbl[6]  = '{1'b0, 3'b010, 32'h101, 32'h0,       0, 32'h0,        '{1'b1, 32'h0,       4'h0, 32'h0,       0, 2}};
    tbl[7]  = '{1'b0, 3'b011, 32'h100, 32'h0,       0, 32'h0,        '{1'b1, 32'h0,       4'h0, 32'h0,       0, 2}};
    tbl[8]  = '{1'b1, 3'b000, 32'h001, 32'h000000A5, 1, 32'h0,       '{1'b0, 32'h0,       4'h2, 32'hA5A5A5A5, 2, 4}};
    tbl[9]  = '{1'b1, 3'b010, 32'h000, 32'h11223344, 2, 32'h0,       '{1'b0, 32'h0,       4'hF, 32'h11223344, 3, 5}};
    tbl[10] = '{1'b1, 3'b100, 32'h000, 32'h55555555, 0, 32'h0,       '{1'b1, 32'h0,       4'h0, 32'h0,       0, 2}};
    tbl[11] = '{1'b0, 3'b001, 32'h101, 32'h0,       0, 32'h0,        '{1'b1, 32'h0,       4'h0, 32'h0,       0, 2}};
    tbl[12] = '{1'b0, 3'b010, 32'h300, 32'h0,       9, 32'h0,        '{1'b1, 32'h0,       4'hF, 32'h0,       4, 6}};
    tbl[13] = '{1'b0, 3'b000, 32'h100, 32'h0,       0, 32'h0000007F, '{1'b0, 32'h0000007F, 4'h1, 32'h0,       1, 3}};
    tbl[14] = '{1'b0, 3'b001, 32'h100, 32'h0,       0, 32'h12348000, '{1'b0, 32'hFFFF8000, 4'h3, 32'h0,       1, 3}};

    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'd0;

    #12;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset mem_req", 32'(mif.mem_req), 32'd0);
    chk("reset mem_we", 32'(mif.mem_we), 32'd0);
    chk("reset mem_addr", mif.mem_addr, 32'd0);
    chk("reset mem_be", 32'(mif.mem_be), 32'd0);
    chk("reset mem_wdata", mif.mem_wdata, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      do_txn(tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].dly, tbl[i].mrd, o);
      check_txn($sformatf("vec%0d", i), o, tbl[i].e, tbl[i].we, tbl[i].a);
    end

    // late mem_ready after a timeout must not produce a completion
    do_txn(1'b0, 3'b010, 32'h500, 32'h0, 20, 32'h0, o);
    chk("to err", 32'(o.err), 32'd1);
    chk("to busy_cycles", o.busy, TO);
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 32'hCAFEF00D;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("late_ready%0d done", k), 32'(done), 32'd0);
      chk($sformatf("late_ready%0d mem_req", k), 32'(mif.mem_req), 32'd0);
      chk($sformatf("late_ready%0d stall", k), 32'(stall), 32'd0);
    end
    mif.mem_ready = 1'b0;
    do_txn(1'b0, 3'b010, 32'h504, 32'h0, 0, 32'h01020304, o);
    check_txn("after_to", o, '{1'b0, 32'h01020304, 4'hF, 32'h0, 1, 3}, 1'b0, 32'h504);

    // reset in the second BUSY cycle
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h400;
    mif.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid busy_before", 32'(mif.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst_mid stall", 32'(stall), 32'd0);
    chk("rst_mid done", 32'(done), 32'd0);
    chk("rst_mid mem_be", 32'(mif.mem_be), 32'd0);
    req_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid no_partial_done", 32'(done), 32'd0);
    chk("rst_mid err", 32'(err), 32'd0);
    do_txn(1'b0, 3'b010, 32'h408, 32'h0, 1, 32'h89ABCDEF, o);
    check_txn("after_rst", o, '{1'b0, 32'h89ABCDEF, 4'hF, 32'h0, 2, 4}, 1'b0, 32'h408);

    for (int i = 0; i < 80; i++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_f3  = 3'($urandom_range(0, 7));
      r_a   = $urandom;
      r_wd  = $urandom;
      r_dly = $urandom_range(0, 5);
      r_mrd = $urandom;
      e = model(r_we, r_f3, r_a, r_wd, r_dly, r_mrd);
      do_txn(r_we, r_f3, r_a, r_wd, r_dly, r_mrd, o);
      check_txn($sformatf("rnd%0d", i), o, e, r_we, r_a);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
